// File: rtl/display_timing_if.sv
// Raster timing bundle produced by display_timing and consumed by the maze/rgb logic.
interface display_timing_if;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       pix_en;
    logic       frame_tick;
    logic       move_clk;

    modport master (
        output hCount, vCount, hSync, vSync, bright, pix_en, frame_tick, move_clk
    );

    modport slave (
        input hCount, vCount, hSync, vSync, bright, pix_en, frame_tick, move_clk
    );
endinterface

// File: rtl/display_timing.sv
// 640x480@60 VGA raster timing: pixel-rate divider, h/v counters, syncs, bright, move_clk.
// Optional move_clk generator is enabled by defining DISPLAY_MOVE_CLK_EN.
module display_timing #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter int MOVE_FRAMES = 1
) (
    input  logic              clk,
    input  logic              Reset,
    display_timing_if.master  vga
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_S   = 10'(H_ACT_START);
    localparam logic [9:0] H_ACT_E   = 10'(H_ACT_END);
    localparam logic [9:0] V_ACT_S   = 10'(V_ACT_START);
    localparam logic [9:0] V_ACT_E   = 10'(V_ACT_END);

    if (MOVE_FRAMES < 1) begin : g_bad_move_frames
        $error("display_timing: MOVE_FRAMES must be at least 1");
    end

    logic [DIV_W-1:0] div;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic             pix_en;
    logic             h_last;
    logic             v_last;
    logic             frame_tick;

    assign pix_en     = (div == DIV_LAST);
    assign h_last     = (h_count == H_LAST);
    assign v_last     = (v_count == V_LAST);
    assign frame_tick = pix_en && h_last && v_last;

    always_ff @(posedge clk) begin
        if (Reset) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_count <= '0;
                v_count <= v_last ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    // Syncs and bright decode straight from the counter registers so they
    // line up with hCount/vCount in the same cycle.
    assign vga.hCount     = h_count;
    assign vga.vCount     = v_count;
    assign vga.hSync      = (h_count >= H_SYNC_W);
    assign vga.vSync      = (v_count >= V_SYNC_W);
    assign vga.bright     = (h_count >= H_ACT_S) && (h_count < H_ACT_E) &&
                            (v_count >= V_ACT_S) && (v_count < V_ACT_E);
    assign vga.pix_en     = pix_en;
    assign vga.frame_tick = frame_tick;

`ifdef DISPLAY_MOVE_CLK_EN
    localparam int FRM_W = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(MOVE_FRAMES - 1);

    logic [FRM_W-1:0] frame_cnt;
    logic             move_q;

    // move_clk flips on the same edge that wraps the raster back to (0,0).
    always_ff @(posedge clk) begin
        if (Reset) begin
            frame_cnt <= '0;
            move_q    <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt <= '0;
                move_q    <= ~move_q;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign vga.move_clk = move_q;
`else
    assign vga.move_clk = 1'b0;
`endif

endmodule
